// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: buffers byte read/write commands in a small FIFO, issues
// them one at a time to an I2C master and returns each result on a
// valid/ready response port.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   cmd_valid/ready/rw/addr/data     command push interface
//   rsp_valid/ready/data/ack_error/timeout  response interface
//   m_write/m_read/m_addr/m_data_wr  strobes and operands to the master
//   m_data_rd/m_done/m_ack_error     results from the master
//   busy, cmd_count                  sequencer activity, FIFO occupancy
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned PULSE_CYCLES   = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [6:0]               cmd_addr,
    input  logic [7:0]               cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_ack_error,
    output logic                     rsp_timeout,
    output logic                     m_write,
    output logic                     m_read,
    output logic [6:0]               m_addr,
    output logic [7:0]               m_data_wr,
    input  logic [7:0]               m_data_rd,
    input  logic                     m_done,
    input  logic                     m_ack_error,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e         state_q, state_d;
    cmd_t           fifo_q [DEPTH];
    cmd_t           cmd_in, head;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           cmd_ready_q;
    logic           push, pop;
    logic           m_done_q, done_rise;
    logic           rw_q, rw_d;
    logic [6:0]     m_addr_q, m_addr_d;
    logic [7:0]     m_data_wr_q, m_data_wr_d;
    logic           m_write_q, m_write_d, m_read_q, m_read_d;
    logic [PW-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_data_q, rsp_data_d;
    logic           rsp_ack_q, rsp_ack_d, rsp_to_q, rsp_to_d;
    logic           busy_q;

    assign cmd_in    = {cmd_rw, cmd_addr, cmd_data};
    assign head      = fifo_q[rd_ptr_q];
    // cmd_ready_q is registered, so a full FIFO never pushes even while popping.
    assign push      = cmd_valid & cmd_ready_q;
    assign done_rise = m_done & ~m_done_q;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        rw_d        = rw_q;
        m_addr_d    = m_addr_q;
        m_data_wr_d = m_data_wr_q;
        m_write_d   = m_write_q;
        m_read_d    = m_read_q;
        pulse_cnt_d = pulse_cnt_q;
        to_cnt_d    = to_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_ack_d   = rsp_ack_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !rsp_valid_q) begin
                    pop         = 1'b1;
                    rw_d        = head.rw;
                    m_addr_d    = head.addr;
                    m_data_wr_d = head.data;
                    m_write_d   = ~head.rw;
                    m_read_d    = head.rw;
                    pulse_cnt_d = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pulse_cnt_q == PW'(PULSE_CYCLES - 1)) begin
                    m_write_d = 1'b0;
                    m_read_d  = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = S_WAIT;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                end
            end
            S_WAIT: begin
                if (done_rise) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rw_q ? m_data_rd : 8'h00;
                    rsp_ack_d   = m_ack_error;
                    rsp_to_d    = 1'b0;
                    state_d     = S_RESP;
                end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_ack_d   = 1'b0;
                    rsp_to_d    = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            m_done_q    <= 1'b0;
            rw_q        <= 1'b0;
            m_addr_q    <= '0;
            m_data_wr_q <= '0;
            m_write_q   <= 1'b0;
            m_read_q    <= 1'b0;
            pulse_cnt_q <= '0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ack_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            cmd_ready_q <= (count_d != CW'(DEPTH));
            m_done_q    <= m_done;
            rw_q        <= rw_d;
            m_addr_q    <= m_addr_d;
            m_data_wr_q <= m_data_wr_d;
            m_write_q   <= m_write_d;
            m_read_q    <= m_read_d;
            pulse_cnt_q <= pulse_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_to_q    <= rsp_to_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign cmd_count     = count_q;
    assign m_write       = m_write_q;
    assign m_read        = m_read_q;
    assign m_addr        = m_addr_q;
    assign m_data_wr     = m_data_wr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_ack_error = rsp_ack_q;
    assign rsp_timeout   = rsp_to_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: directed table, backpressure,
// async reset and randomized traffic against a transaction-level model.
module tb_i2c_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PULSE = 6;
    localparam int unsigned TMO   = 50;
    localparam logic [6:0]  A_NACK = 7'h7F;   // slave answers with NACK
    localparam logic [6:0]  A_HANG = 7'h7E;   // slave never signals done

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic [7:0] data;
        logic       ack;
        logic       to;
    } rsp_t;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] e_data;
        logic       e_ack;
        logic       e_to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_ack_error, rsp_timeout;
    logic       m_write, m_read;
    logic [6:0] m_addr;
    logic [7:0] m_data_wr, m_data_rd;
    logic       m_done, m_ack_error;
    logic       busy;
    logic [2:0] cmd_count;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ack_error(rsp_ack_error), .rsp_timeout(rsp_timeout),
        .m_write(m_write), .m_read(m_read), .m_addr(m_addr), .m_data_wr(m_data_wr),
        .m_data_rd(m_data_rd), .m_done(m_done), .m_ack_error(m_ack_error),
        .busy(busy), .cmd_count(cmd_count)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    cmd_t        exp_q[$];
    logic [7:0]  ref_mem [128];
    logic [7:0]  slv_mem [128];
    int          rsp_cnt = 0;
    int          issue_cnt = 0;
    int          last_gap = -1;
    rsp_t        last_rsp;
    logic        rsp_hold = 1'b0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result of one transaction from the slave's documented behaviour.
    function automatic rsp_t expect_rsp(input cmd_t c);
        rsp_t r;
        r.to   = (c.addr == A_HANG);
        r.ack  = !r.to && (c.addr == A_NACK);
        r.data = (r.to || !c.rw) ? 8'h00 : ref_mem[c.addr];
        return r;
    endfunction

    // Slave: raises done a random delay after the strobe ends, holds it 2 cycles.
    initial begin : slave
        int         cd;
        int         hold;
        logic       ps, prd, s_rw;
        logic [6:0] s_addr;
        logic [7:0] s_data;
        cd = -1; hold = 0; ps = 1'b0; prd = 1'b0;
        s_rw = 1'b0; s_addr = '0; s_data = '0;
        m_done = 1'b0; m_ack_error = 1'b0; m_data_rd = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cd = -1; hold = 0; ps = 1'b0; m_done = 1'b0; m_ack_error = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) begin m_done = 1'b0; m_ack_error = 1'b0; end
                end
                if (cd > 0) cd--;
                else if (cd == 0) begin
                    cd = -1;
                    if (s_addr != A_HANG) begin
                        m_done      = 1'b1;
                        hold        = 2;
                        m_ack_error = (s_addr == A_NACK);
                        if (s_rw) m_data_rd = slv_mem[s_addr];
                        else if (s_addr != A_NACK) slv_mem[s_addr] = s_data;
                    end
                end
                if (ps && !(m_write || m_read)) begin
                    cd = $urandom_range(0, 5);
                    s_rw = prd; s_addr = m_addr; s_data = m_data_wr;
                end
                ps  = m_write || m_read;
                prd = m_read;
            end
        end
    end

    // Monitor / scoreboard / response consumer.
    initial begin : monitor
        logic ps, cur_v, rv_prev, hs_seen, strobe;
        int   width, wait_start, hs_cyc;
        cmd_t cur;
        rsp_t e;
        ps = 1'b0; cur_v = 1'b0; rv_prev = 1'b0; hs_seen = 1'b0;
        width = 0; wait_start = 0; hs_cyc = 0; cur = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                ps = 1'b0; cur_v = 1'b0; rv_prev = 1'b0; hs_seen = 1'b0; width = 0;
                rsp_ready = 1'b0;
            end else begin
                strobe = m_write || m_read;
                if (m_write && m_read) chk("strobe_exclusive", 32'd1, 32'd0);
                if (strobe && !ps) begin
                    issue_cnt++;
                    chk("busy_on_issue", 32'(busy), 32'd1);
                    if (exp_q.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
                    else begin
                        cur   = exp_q.pop_front();
                        cur_v = 1'b1;
                        chk("issue_kind", 32'({m_read, m_write}), cur.rw ? 32'd2 : 32'd1);
                        chk("issue_addr", 32'(m_addr), 32'(cur.addr));
                        if (!cur.rw) chk("issue_wdata", 32'(m_data_wr), 32'(cur.data));
                    end
                    if (hs_seen) begin
                        last_gap = cyc - hs_cyc;
                        chk("issue_gap_ok", 32'(last_gap >= 2), 32'd1);
                        hs_seen = 1'b0;
                    end
                    width = 0;
                end
                if (strobe) width++;
                if (!strobe && ps) begin
                    chk("pulse_width", 32'(width), 32'(PULSE));
                    wait_start = cyc;
                end
                if (rsp_valid && !rv_prev) begin
                    if (!cur_v) chk("rsp_unexpected", 32'd1, 32'd0);
                    else if (cur.addr == A_HANG)
                        chk("timeout_latency", 32'(cyc - wait_start), 32'(TMO));
                end
                rsp_ready = rsp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (rsp_valid && rsp_ready && cur_v) begin
                    e = expect_rsp(cur);
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_ack_error", 32'(rsp_ack_error), 32'(e.ack));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    if (!cur.rw && !e.to && !e.ack) ref_mem[cur.addr] = cur.data;
                    last_rsp = '{data: rsp_data, ack: rsp_ack_error, to: rsp_timeout};
                    rsp_cnt++;
                    hs_cyc  = cyc;
                    hs_seen = 1'b1;
                    cur_v   = 1'b0;
                end
                rv_prev = rsp_valid;
                ps      = strobe;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input cmd_t c);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_rw = c.rw; cmd_addr = c.addr; cmd_data = c.data;
        while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            chk("push_accept", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(c);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string name);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 3000) begin @(negedge clk); n++; end
        chk(name, 32'(rsp_cnt >= target), 32'd1);
    endtask

    vec_t vt [9];

    initial begin : main
        cmd_t c;
        int   base, ibase, n;
        rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = 8'(i * 5 + 3);
            slv_mem[i] = 8'(i * 5 + 3);
        end
        //          rw    addr   data   e_data e_ack e_to
        vt[0] = '{1'b0, 7'h19, 8'h59, 8'h00, 1'b0, 1'b0};
        vt[1] = '{1'b1, 7'h19, 8'h00, 8'h59, 1'b0, 1'b0};
        vt[2] = '{1'b0, 7'h7F, 8'hAA, 8'h00, 1'b1, 1'b0};
        vt[3] = '{1'b1, 7'h22, 8'h00, 8'hAD, 1'b0, 1'b0};
        vt[4] = '{1'b0, 7'h7E, 8'h11, 8'h00, 1'b0, 1'b1};
        vt[5] = '{1'b1, 7'h7E, 8'h00, 8'h00, 1'b0, 1'b1};
        vt[6] = '{1'b0, 7'h05, 8'hC3, 8'h00, 1'b0, 1'b0};
        vt[7] = '{1'b1, 7'h05, 8'h00, 8'hC3, 1'b0, 1'b0};
        vt[8] = '{1'b1, 7'h7F, 8'h00, 8'h7E, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({m_write, m_read}), 32'd0);
        chk("rst_m_operands", 32'({m_addr, m_data_wr}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_data, rsp_ack_error, rsp_timeout}), 32'd0);
        chk("rst_busy_count", 32'({busy, cmd_count}), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Directed table, one transaction at a time.
        for (int i = 0; i < 9; i++) begin
            base = rsp_cnt;
            c = '{rw: vt[i].rw, addr: vt[i].addr, data: vt[i].data};
            push(c);
            wait_rsp(base + 1, $sformatf("dir%0d_done", i));
            chk($sformatf("dir%0d_data", i), 32'(last_rsp.data), 32'(vt[i].e_data));
            chk($sformatf("dir%0d_ack", i), 32'(last_rsp.ack), 32'(vt[i].e_ack));
            chk($sformatf("dir%0d_to", i), 32'(last_rsp.to), 32'(vt[i].e_to));
        end
        chk("slave_byte_19", 32'(slv_mem[7'h19]), 32'h59);

        // Backpressure: response held, 5 commands -> 1 in flight, 4 buffered.
        repeat (4) @(negedge clk);
        rsp_hold = 1'b1;
        base = rsp_cnt; ibase = issue_cnt;
        for (int i = 0; i < 5; i++) begin
            c = '{rw: 1'(i & 1), addr: 7'(8'h30 + 8'(i)), data: 8'(8'h40 + 8'(i))};
            push(c);
        end
        n = 0;
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_cmd_count", 32'(cmd_count), 32'd4);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_one_issue", 32'(issue_cnt - ibase), 32'd1);
        rsp_hold = 1'b0;
        n = 0;
        while (issue_cnt < ibase + 2 && n < 500) begin @(negedge clk); n++; end
        chk("bp_second_issue", 32'(issue_cnt - ibase), 32'd2);
        chk("bp_issue_gap", 32'(last_gap), 32'd2);
        wait_rsp(base + 5, "bp_drain");

        // Async reset in WAIT with two commands queued.
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            c = '{rw: 1'b0, addr: A_HANG, data: 8'(i)};
            push(c);
        end
        repeat (10) @(negedge clk);
        chk("pre_rst_count", 32'(cmd_count), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_waiting", 32'({m_write, m_read, rsp_valid}), 32'd0);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_strobes", 32'({m_write, m_read}), 32'd0);
        chk("arst_count", 32'(cmd_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        base = rsp_cnt; ibase = issue_cnt;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        repeat (100) @(negedge clk);
        chk("post_rst_no_rsp", 32'(rsp_cnt - base), 32'd0);
        chk("post_rst_no_issue", 32'(issue_cnt - ibase), 32'd0);
        chk("post_rst_idle", 32'({busy, rsp_valid, cmd_count}), 32'd0);

        // Randomized traffic against the scoreboard.
        base = rsp_cnt;
        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            c.rw   = 1'($urandom_range(0, 1));
            c.addr = (r == 0) ? A_HANG : (r == 1) ? A_NACK : 7'($urandom_range(0, 125));
            c.data = 8'($urandom);
            push(c);
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_rsp(base + 40, "rand_drain");
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Host-side command front end that sits directly upstream of the I2C master.
- Accepts byte read/write commands on a valid/ready interface and buffers them in a small FIFO.
- Issues them one at a time to the master's write/read/addr/data_wr inputs, then waits for the master's done.
- Returns each result (read data, ack_error, timeout flag) on a valid/ready response interface, so software or a test controller can queue transactions without tracking bus timing.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
PULSE_CYCLES, 1000, clk cycles m_write/m_read held high per issue (≥1; default covers one SCL period at 100 kbps/100 MHz)
TIMEOUT_CYCLES, 200000, clk cycles allowed in WAIT before declaring timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_rw  in  1  1=read, 0=write
cmd_addr  in  7  target slave address
cmd_data  in  8  write byte (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  read byte; 0 for writes/timeouts
rsp_ack_error  out  1  master reported NACK
rsp_timeout  out  1  master never signalled done
m_write  out  1  write strobe to master
m_read  out  1  read strobe to master
m_addr  out  7  address to master
m_data_wr  out  8  write byte to master
m_data_rd  in  8  read byte from master
m_done  in  1  master transaction complete (level)
m_ack_error  in  1  master NACK flag, valid with m_done
busy  out  1  state != IDLE
cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO empty, cmd_count=0, state IDLE; all outputs low/zero, including m_write, m_read, m_addr, m_data_wr, rsp_*, busy. cmd_ready rises the first cycle after rst deasserts.
- FIFO:
  - cmd_ready = (cmd_count != DEPTH).
  - Push on cmd_valid & cmd_ready; pointers wrap modulo DEPTH.
  - Pop only in IDLE → ISSUE.
  - Push and pop in the same cycle leave count unchanged.
  - When full, no push occurs even if a pop happens that cycle.
- m_done edge detect: done_rise = m_done & ~m_done_q (m_done_q registered).
- FSM:
  - IDLE: if FIFO non-empty and rsp_valid=0 → pop the head, latch rw/addr/data into m_addr/m_data_wr, go ISSUE.
  - ISSUE: assert m_write (rw=0) or m_read (rw=1) for exactly PULSE_CYCLES cycles, then deassert and go WAIT. Timeout counter clears on entry.
  - WAIT:
    - On done_rise: rsp_data = rw ? m_data_rd : 0; rsp_ack_error = m_ack_error; rsp_timeout = 0; go RESP.
    - Else if timeout counter reaches TIMEOUT_CYCLES-1: rsp_data=0, rsp_ack_error=0, rsp_timeout=1; go RESP.
    - done_rise is ignored in ISSUE and IDLE.
  - RESP: rsp_valid=1, with rsp_* held stable until rsp_ready. On rsp_valid & rsp_ready, rsp_valid drops the next cycle and the FSM goes IDLE. A new command can issue the cycle after that at the earliest.
- m_addr/m_data_wr stay constant from ISSUE through RESP and change only on the next pop.
- m_write and m_read are never high together.
- Minimum issue-to-response latency: PULSE_CYCLES + 1 cycles after done_rise registers.
- Reset mid-transaction: immediate abort. Strobes drop asynchronously, queued commands are discarded, and no response is produced.

Test Plan:
- Write: push rw=0, addr=7'h19, data=8'h59 → m_write high 1000 cycles with m_addr=7'h19 and m_data_wr=8'h59; after m_done rise → rsp_valid, rsp_data=0, ack_error=0, timeout=0; the slave-side byte equals 8'h59.
- Read: push rw=1, addr=7'h19, slave returns 8'h59 → m_read pulse, no m_write; rsp_data=8'h59, ack_error=0.
- NACK: push write to unused addr=7'h7F with master ack_error=1 at done → rsp_ack_error=1, rsp_data=0; the next queued command still issues.
- Backpressure: hold rsp_ready=0, push 5 commands with DEPTH=4 → 1 command popped, then 4 buffered; cmd_ready=0 with cmd_count=4; the next issue occurs only after rsp_ready=1 for one cycle.
- Timeout: tie m_done=0, TIMEOUT_CYCLES=50 → rsp_timeout=1 exactly 50 cycles after entering WAIT, with rsp_data=0.
- Async reset mid-WAIT with 2 commands queued → m_read/m_write=0, cmd_count=0, busy=0, rsp_valid=0 immediately; no response after release.
